truth_table_sweeper: RTL and testbench

- Sequential controller that drives a combinational switch-level scheme with an N-bit input vector.
- Steps through every input combination, waits a settle interval per vector, samples the scheme output and builds its truth table.
- Compares the built table against an expected table and reports pass/fail, the mismatch count and the first failing vector.
- Sits between a bench or host and any transistor-level combinational block, replacing open-loop initial-block sweeps with a clocked, restartable sequencer.

---
 rtl/truth_sweep_pkg.sv | 18 +
 rtl/sweep_settle_timer.sv | 27 ++
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 2;

  function automatic int table_size(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter timing the settle interval; zero flags expiry.
module sweep_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sequencer: sweeps every input vector of a combinational scheme,
// captures its truth table and scores it against a latched golden table.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [table_size(N_IN)-1:0] expected,
  output logic [N_IN-1:0]             dut_x,
  input  logic                        dut_y,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [table_size(N_IN)-1:0] table_out,
  output logic [N_IN:0]               err_count,
  output logic [N_IN-1:0]             first_fail,
  output logic                        fail_valid,
  output logic                        xz_seen
);

  localparam int TBL = table_size(N_IN);
  localparam int CW  = 4;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TBL - 1);

  state_t          state;
  logic [TBL-1:0]  exp_q;
  logic [N_IN-1:0] idx;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic            y_bin;
  logic            y_xz;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  assign tmr_load = (state == IDLE && start) ||
                    (state == SAMPLE && !abort && idx != LAST_IDX);
  assign tmr_dec  = (state == WAIT);

  sweep_settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CW'(SETTLE - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Anything other than a clean 0/1 (x or z) is flagged and forced to a mismatch.
  always_comb begin
    y_bin = 1'b0;
    y_xz  = 1'b0;
    case (dut_y)
      1'b0:    y_bin = 1'b0;
      1'b1:    y_bin = 1'b1;
      default: y_xz  = 1'b1;
    endcase
  end

  assign mismatch = y_xz || (y_bin != exp_q[idx]);
  assign err_next = err_count + (N_IN + 1)'(mismatch);
  assign dut_x    = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_q      <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      table_out  <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      xz_seen    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q      <= expected;
            table_out  <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            xz_seen    <= 1'b0;
            pass       <= 1'b0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            idx   <= '0;
          end else if (tmr_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            idx   <= '0;
          end else begin
            table_out[idx] <= y_bin;
            xz_seen        <= xz_seen | y_xz;
            if (mismatch) begin
              err_count <= err_next;
              if (!fail_valid) begin
                first_fail <= idx;
                fail_valid <= 1'b1;
              end
            end
            // pass uses err_next so the final vector is included.
            if (idx == LAST_IDX) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              idx   <= '0;
            end else begin
              idx   <= idx + N_IN'(1);
              state <= WAIT;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus pushes expected sweep results, monitors pop on done.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        fv;
    logic        xz;
    logic        pass;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_seen0 = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  logic        start0 = 1'b0, abort0 = 1'b0, zmode = 1'b0;
  logic [15:0] expected0 = '0;
  logic [3:0]  dut_x0;
  logic        y0, busy0, done0, pass0, fv0, xz0;
  logic [15:0] table0;
  logic [4:0]  err0;
  logic [3:0]  ff0;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [15:0] expected1 = '0;
  logic [3:0]  dut_x1;
  logic        y1, busy1, done1, pass1, fv1, xz1;
  logic [15:0] table1;
  logic [4:0]  err1;
  logic [3:0]  ff1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb y0 = zmode ? 1'bz : dut_x0[0];
  assign y1 = ~dut_x1[3];

  truth_table_sweeper u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(expected0),
    .dut_x(dut_x0), .dut_y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .table_out(table0), .err_count(err0), .first_fail(ff0), .fail_valid(fv0),
    .xz_seen(xz0)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected1),
    .dut_x(dut_x1), .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table1), .err_count(err1), .first_fail(ff1), .fail_valid(fv1),
    .xz_seen(xz1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [15:0] tbl,
                         input logic [4:0] err, input logic [3:0] ff, input logic fv,
                         input logic xz, input logic ps, input logic bsy);
    chk({tag, "_table"}, tbl, e.tbl);
    chk({tag, "_err_count"}, err, e.err);
    chk({tag, "_first_fail"}, ff, e.ff);
    chk({tag, "_fail_valid"}, fv, e.fv);
    chk({tag, "_xz_seen"}, xz, e.xz);
    chk({tag, "_pass"}, ps, e.pass);
    chk({tag, "_busy_at_done"}, bsy, 1'b0);
    chk({tag, "_done_latency"}, cyc, e.done_cyc);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      done_seen0++;
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else compare("u0", q0.pop_front(), table0, err0, ff0, fv0, xz0, pass0, busy0);
    end
    if (done1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else compare("u1", q1.pop_front(), table1, err1, ff1, fv1, xz1, pass1, busy1);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_sweep0(input logic [15:0] e, input logic with_abort, output int cap);
    @(negedge clk);
    expected0 = e;
    start0 = 1'b1;
    abort0 = with_abort;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    cap = cyc;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("drain_timeout", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cap;
    int seen;
    #3;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_table", table0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fv_xz_ff", {fv0, xz0, ff0}, 0);
    chk("rst_dut_x", dut_x0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep; a second start and a changed golden table mid-sweep are ignored.
    start_sweep0(16'hAAAA, 1'b0, cap);
    q0.push_back('{16'hAAAA, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, cap + 48});
    chk("busy_after_start", busy0, 1);
    wait_cyc(cap + 9);
    start0 = 1'b1;
    expected0 = 16'h0000;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_mid_sweep", busy0, 1);
    drain(200);
    repeat (3) @(negedge clk);
    chk("pass_hold", pass0, 1);
    chk("table_hold", table0, 16'hAAAA);
    chk("idle_dut_x", dut_x0, 0);

    // Abort at edge 20: vectors 0..5 sampled, mismatches at 1, 3, 5.
    start_sweep0(16'h0000, 1'b0, cap);
    wait_cyc(cap + 19);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_pass", pass0, 0);
    chk("abort_dut_x", dut_x0, 0);
    chk("abort_err_count", err0, 3);
    chk("abort_table", table0, 16'h002A);
    chk("abort_first_fail", {fv0, ff0}, 5'h11);
    seen = done_seen0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_seen0, seen);

    // Asynchronous reset mid-sweep.
    start_sweep0(16'hAAAA, 1'b0, cap);
    wait_cyc(cap + 29);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_table", table0, 0);
    chk("arst_dut_x", dut_x0, 0);
    chk("arst_misc", {done0, pass0, err0, ff0, fv0, xz0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start with abort in IDLE: start wins. Single mismatch at vector 1.
    start_sweep0(16'hAAA8, 1'b1, cap);
    q0.push_back('{16'hAAAA, 5'd1, 4'd1, 1'b1, 1'b0, 1'b0, cap + 48});
    drain(200);

    // Output held at z; a 2-state simulator resolves it to 0 before the DUT sees it.
    zmode = 1'b1;
    #1;
    start_sweep0(16'h0F0F, 1'b0, cap);
    if ($isunknown(y0))
      q0.push_back('{16'h0000, 5'd16, 4'd0, 1'b1, 1'b1, 1'b0, cap + 48});
    else
      q0.push_back('{16'h0000, 5'd8, 4'd0, 1'b1, 1'b0, 1'b0, cap + 48});
    drain(200);
    zmode = 1'b0;

    // SETTLE=1 instance: each vector lasts two cycles.
    @(negedge clk);
    expected1 = 16'h00FF;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cap = cyc;
    q1.push_back('{16'h00FF, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, cap + 32});
    for (int k = 0; k < 32; k++) begin
      wait_cyc(cap + k);
      chk("u1_dut_x_step", dut_x1, k / 2);
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
